// File: rtl/sac_pkg.sv
// Shared types and sizing helpers for the serial adder / magnitude comparator.
package sac_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef enum logic [1:0] {CMP_EQ, CMP_LT, CMP_GT} cmp_t;

   function automatic int sac_steps(input int width, input int digit);
      return width / digit;
   endfunction

   // Step counter needs at least one bit even when a single step covers the word.
   function automatic int sac_cnt_w(input int width, input int digit);
      int s;
      s = width / digit;
      return (s < 2) ? 1 : $clog2(s);
   endfunction

endpackage

// File: rtl/serial_digit_adder.sv
// DIGIT-bit combinational ripple adder; also exposes the carry into its top bit.
module serial_digit_adder #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic             cin,
   output logic [DIGIT-1:0] s_d,
   output logic             cout,
   output logic             c_msb
);

   logic [DIGIT:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign s_d[i]   = a_d[i] ^ b_d[i] ^ c[i];
      assign c[i+1]   = (a_d[i] & b_d[i]) | (c[i] & (a_d[i] ^ b_d[i]));
   end

   assign cout  = c[DIGIT];
   assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_add_compare.sv
// Multi-cycle adder and magnitude comparator, DIGIT bits per clock, LSB first,
// behind valid/ready handshakes on both sides.
module serial_add_compare
   import sac_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGIT  = 1,
   parameter bit SIGNED = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             a_lt_b,
   output logic             a_eq_b,
   output logic             a_gt_b,
   output logic             busy
);

   localparam int STEPS = sac_steps(WIDTH, DIGIT);
   localparam int CW    = sac_cnt_w(WIDTH, DIGIT);
   // Flipping the sign bit maps two's-complement order onto unsigned order.
   localparam logic [WIDTH-1:0] MSB_FLIP = SIGNED ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

   state_t           state, state_nxt;
   cmp_t             cmp, cmp_nxt;
   logic [CW-1:0]    step;
   logic [WIDTH-1:0] a_sh, b_sh, ca_sh, cb_sh, sum_sh, sum_shifted;
   logic             carry, last;
   logic [DIGIT-1:0] s_d;
   logic             d_cout, d_cmsb;
   logic             cout_r, ovf_r, lt_r, eq_r, gt_r;

   serial_digit_adder #(.DIGIT(DIGIT)) u_add (
      .a_d   (a_sh[DIGIT-1:0]),
      .b_d   (b_sh[DIGIT-1:0]),
      .cin   (carry),
      .s_d   (s_d),
      .cout  (d_cout),
      .c_msb (d_cmsb)
   );

   if (STEPS == 1) begin : g_one
      assign sum_shifted = s_d;
   end else begin : g_many
      assign sum_shifted = {s_d, sum_sh[WIDTH-1:DIGIT]};
   end

   assign last = (step == CW'(STEPS-1));

   always_comb begin
      cmp_nxt = cmp;
      if (ca_sh[DIGIT-1:0] > cb_sh[DIGIT-1:0])      cmp_nxt = CMP_GT;
      else if (ca_sh[DIGIT-1:0] < cb_sh[DIGIT-1:0]) cmp_nxt = CMP_LT;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = RUN;
         RUN:     if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         ca_sh  <= '0;
         cb_sh  <= '0;
         sum_sh <= '0;
         carry  <= 1'b0;
         cmp    <= CMP_EQ;
         step   <= '0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
         lt_r   <= 1'b0;
         eq_r   <= 1'b0;
         gt_r   <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         a_sh  <= a;
         b_sh  <= b;
         ca_sh <= a ^ MSB_FLIP;
         cb_sh <= b ^ MSB_FLIP;
         carry <= 1'b0;
         cmp   <= CMP_EQ;
         step  <= '0;
      end else if (state == RUN) begin
         a_sh   <= a_sh >> DIGIT;
         b_sh   <= b_sh >> DIGIT;
         ca_sh  <= ca_sh >> DIGIT;
         cb_sh  <= cb_sh >> DIGIT;
         sum_sh <= sum_shifted;
         carry  <= d_cout;
         cmp    <= cmp_nxt;
         step   <= step + 1'b1;
         if (last) begin
            cout_r <= d_cout;
            ovf_r  <= SIGNED && (d_cmsb ^ d_cout);
            lt_r   <= (cmp_nxt == CMP_LT);
            eq_r   <= (cmp_nxt == CMP_EQ);
            gt_r   <= (cmp_nxt == CMP_GT);
         end
      end
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);
   assign sum       = sum_sh;
   assign cout      = cout_r;
   assign ovf       = ovf_r;
   assign a_lt_b    = lt_r;
   assign a_eq_b    = eq_r;
   assign a_gt_b    = gt_r;

endmodule

// File: tb/tb_serial_add_compare.sv
// Directed and model-checked bench over four configurations of serial_add_compare.
module tb_serial_add_compare;

   // instance 0: W8 D1 unsigned, 1: W8 D1 signed, 2: W3 D1 unsigned, 3: W8 D4 unsigned
   logic            clk = 1'b0;
   logic            rst_n;
   logic [3:0]      iv, ordy;
   logic [3:0][7:0] av, bv;
   wire  [3:0][7:0] sm;
   wire  [3:0]      co, ov_f, lt, eq, gt, ov, rdy, bsy;
   wire  [2:0]      sum3;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   serial_add_compare #(.WIDTH(8), .DIGIT(1), .SIGNED(1'b0)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]), .a(av[0]), .b(bv[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sm[0]), .cout(co[0]), .ovf(ov_f[0]),
      .a_lt_b(lt[0]), .a_eq_b(eq[0]), .a_gt_b(gt[0]), .busy(bsy[0]));

   serial_add_compare #(.WIDTH(8), .DIGIT(1), .SIGNED(1'b1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]), .a(av[1]), .b(bv[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sm[1]), .cout(co[1]), .ovf(ov_f[1]),
      .a_lt_b(lt[1]), .a_eq_b(eq[1]), .a_gt_b(gt[1]), .busy(bsy[1]));

   serial_add_compare #(.WIDTH(3), .DIGIT(1), .SIGNED(1'b0)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy[2]), .a(av[2][2:0]), .b(bv[2][2:0]),
      .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sum3), .cout(co[2]), .ovf(ov_f[2]),
      .a_lt_b(lt[2]), .a_eq_b(eq[2]), .a_gt_b(gt[2]), .busy(bsy[2]));

   assign sm[2] = {5'b0, sum3};

   serial_add_compare #(.WIDTH(8), .DIGIT(4), .SIGNED(1'b0)) u3 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(rdy[3]), .a(av[3]), .b(bv[3]),
      .out_valid(ov[3]), .out_ready(ordy[3]), .sum(sm[3]), .cout(co[3]), .ovf(ov_f[3]),
      .a_lt_b(lt[3]), .a_eq_b(eq[3]), .a_gt_b(gt[3]), .busy(bsy[3]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // {cout, ovf, lt, eq, gt, sum}
   function automatic logic [12:0] res(input int s);
      return {co[s], ov_f[s], lt[s], eq[s], gt[s], sm[s]};
   endfunction

   function automatic logic [12:0] mk(input logic c, input logic o, input logic l,
                                      input logic e, input logic g, input logic [7:0] s);
      return {c, o, l, e, g, s};
   endfunction

   task automatic run_x(input int s, input logic [7:0] x, input logic [7:0] y,
                        input int exp_lat, input logic [12:0] exp, input string tag);
      int lat;
      @(negedge clk);
      chk({tag, "/in_ready"}, 32'(rdy[s]), 32'd1);
      av[s] = x; bv[s] = y; iv[s] = 1'b1;
      @(negedge clk);
      // operands are scrambled right after acceptance; the result must not care
      iv[s] = 1'b0; av[s] = ~x; bv[s] = x ^ 8'h3c;
      lat = 0;
      while (!ov[s] && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "/result"}, 32'(res(s)), 32'(exp));
      ordy[s] = 1'b1;
      @(negedge clk);
      ordy[s] = 1'b0;
      chk({tag, "/release"}, 32'({ov[s], rdy[s], bsy[s]}), 32'b010);
   endtask

   initial begin
      logic [12:0] snap;
      int          lat, t, x, y;

      rst_n = 1'b0; iv = '0; ordy = '0; av = '0; bv = '0;
      #12;
      chk("reset/outs", 32'(res(0)), 32'd0);
      chk("reset/hs", 32'({ov[0], rdy[0], bsy[0]}), 32'b010);
      @(negedge clk);
      rst_n = 1'b1;

      run_x(0, 8'd200, 8'd100, 8, mk(1, 0, 0, 0, 1, 8'd44),   "u_200_100");
      run_x(0, 8'h01,  8'h80,  8, mk(0, 0, 1, 0, 0, 8'h81),   "u_01_80");
      run_x(0, 8'h80,  8'h01,  8, mk(0, 0, 0, 0, 1, 8'h81),   "u_80_01");
      run_x(0, 8'h80,  8'h80,  8, mk(1, 0, 0, 1, 0, 8'h00),   "u_80_80");

      run_x(1, 8'h80, 8'h01, 8, mk(0, 0, 1, 0, 0, 8'h81), "s_80_01");
      run_x(1, 8'h7F, 8'h01, 8, mk(0, 1, 0, 0, 1, 8'h80), "s_7f_01");
      run_x(1, 8'hFF, 8'h01, 8, mk(1, 0, 1, 0, 0, 8'h00), "s_ff_01");
      run_x(1, 8'h80, 8'h80, 8, mk(1, 1, 0, 1, 0, 8'h00), "s_80_80");

      // back-pressure: result held, extra operands not consumed
      @(negedge clk);
      av[0] = 8'h5A; bv[0] = 8'h5A; iv[0] = 1'b1;
      @(negedge clk);
      iv[0] = 1'b0;
      lat = 0;
      while (!ov[0] && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      chk("bp/latency", 32'(lat), 32'd8);
      snap = res(0);
      chk("bp/result", 32'(snap), 32'(mk(0, 0, 0, 1, 0, 8'hB4)));
      for (int k = 0; k < 5; k++) begin
         iv[0] = 1'b1; av[0] = 8'(8'h11 * k); bv[0] = 8'h03;
         @(negedge clk);
         chk("bp/hold", 32'({res(0), ov[0], rdy[0]}), 32'({snap, 2'b10}));
      end
      iv[0] = 1'b0;
      ordy[0] = 1'b1;
      @(negedge clk);
      ordy[0] = 1'b0;
      chk("bp/release", 32'({ov[0], rdy[0], bsy[0]}), 32'b010);
      @(negedge clk);
      chk("bp/not_consumed", 32'(bsy[0]), 32'd0);

      // asynchronous reset three steps into a run
      av[0] = 8'd200; bv[0] = 8'd100; iv[0] = 1'b1;
      @(negedge clk);
      iv[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst/mid_run_busy", 32'(bsy[0]), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst/outs", 32'(res(0)), 32'd0);
      chk("rst/hs", 32'({ov[0], rdy[0], bsy[0]}), 32'b010);
      @(negedge clk);
      rst_n = 1'b1;
      run_x(0, 8'd3, 8'd4, 8, mk(0, 0, 1, 0, 0, 8'd7), "rst/next");

      for (x = 0; x < 8; x++)
         for (y = 0; y < 8; y++) begin
            t = x + y;
            run_x(2, 8'(x), 8'(y), 3,
                  mk(t[3], 1'b0, x < y, x == y, x > y, {5'b0, t[2:0]}), "w3");
         end

      run_x(3, 8'hFF, 8'hFF, 2, mk(1, 0, 0, 1, 0, 8'hFE), "d4_ff_ff");
      run_x(3, 8'h00, 8'h00, 2, mk(0, 0, 0, 1, 0, 8'h00), "d4_00_00");
      run_x(3, 8'h1F, 8'h20, 2, mk(0, 0, 1, 0, 0, 8'h3F), "d4_1f_20");
      for (int k = 0; k < 150; k++) begin
         x = int'($urandom_range(0, 255));
         y = int'($urandom_range(0, 255));
         t = x + y;
         run_x(3, 8'(x), 8'(y), 2,
               mk(t[8], 1'b0, x < y, x == y, x > y, t[7:0]), "d4_rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
